stream_copy: RTL

Parametrised buffer-to-buffer streaming copy engine for the accelerator side of the hc buffer interface. After `start` it reads `num_lines` cache lines from a source buffer, optionally transforms them, and writes them in order to a destination buffer. Read requests are credit-limited so the internal FIFO can never overflow. `finish` is raised only after every write has been acknowledged. It replaces fixed-length, fixed-depth loopback blocks, which had no flow control and no completion signal.

---
 rtl/stream_copy.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/stream_copy.sv
// rtl/stream_copy.sv - credit-limited buffer-to-buffer streaming copy engine
module stream_copy #(
  parameter int DATA_WIDTH   = 512,
  parameter int FIFO_DEPTH   = 32,
  parameter int LEN_WIDTH    = 16,
  parameter int CHUNK_MAX    = 8,
  parameter int BUF_ID_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [LEN_WIDTH-1:0]           num_lines,
  input  logic [BUF_ID_WIDTH-1:0]        src_buf,
  input  logic [BUF_ID_WIDTH-1:0]        dst_buf,
  input  logic                           mode,
  output logic                           busy,
  output logic                           finish,
  output logic                           rd_req_valid,
  input  logic                           rd_req_ready,
  output logic [BUF_ID_WIDTH-1:0]        rd_req_buf,
  output logic [$clog2(CHUNK_MAX+1)-1:0] rd_req_len,
  input  logic                           rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0]          rd_rsp_data,
  output logic                           wr_req_valid,
  input  logic                           wr_full,
  output logic [BUF_ID_WIDTH-1:0]        wr_req_buf,
  output logic [DATA_WIDTH-1:0]          wr_req_data,
  input  logic                           wr_ack
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int RLW = $clog2(CHUNK_MAX + 1);
  localparam int CRW = LEN_WIDTH + 1;

  typedef logic [CRW-1:0] cr_t;
  typedef logic [RLW-1:0] rl_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                  state_q;
  logic                    busy_q, finish_q, mode_q;
  logic [LEN_WIDTH-1:0]    len_q, req_left_q, inflight_q, acks_q;
  logic [BUF_ID_WIDTH-1:0] src_q, dst_q;
  logic                    rd_valid_q;
  rl_t                     rd_len_q;

  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic                    wr_valid_q, wr_valid_d;
  logic [DATA_WIDTH-1:0]   wr_data_q;

  logic                    active, rd_acc, wr_acc, enq, out_load, deq, drained;
  logic [LEN_WIDTH-1:0]    req_left_d, inflight_d, acks_d;
  cr_t                     credit;

  // Request length is the smallest of lines still to request, free credit and the chunk cap
  function automatic rl_t pick_len(cr_t left, cr_t cred);
    cr_t m;
    m = left;
    if (cred < m) m = cred;
    if (cr_t'(CHUNK_MAX) < m) m = cr_t'(CHUNK_MAX);
    return rl_t'(m);
  endfunction

  // Handshakes, next-state counters and credit; the output register counts as occupancy
  always_comb begin
    active     = (state_q == S_RUN) || (state_q == S_DRAIN);
    rd_acc     = rd_valid_q && rd_req_ready;
    wr_acc     = wr_valid_q && !wr_full;
    enq        = active && rd_rsp_valid;
    out_load   = !wr_valid_q || wr_acc;
    deq        = out_load && (count_q != '0);
    count_d    = count_q + CW'(enq) - CW'(deq);
    wr_valid_d = out_load ? (count_q != '0) : wr_valid_q;
    req_left_d = rd_acc ? (req_left_q - LEN_WIDTH'(rd_len_q)) : req_left_q;
    inflight_d = inflight_q + (rd_acc ? LEN_WIDTH'(rd_len_q) : '0) - LEN_WIDTH'(enq);
    acks_d     = acks_q + LEN_WIDTH'(active && wr_ack);
    credit     = cr_t'(FIFO_DEPTH) - cr_t'(count_q) - cr_t'(inflight_q) - cr_t'(wr_valid_q);
    drained    = (acks_d == len_q) && (count_d == '0) && !wr_valid_d;
  end

  // Control FSM: job capture, read-request issue, completion tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
      mode_q     <= 1'b0;
      len_q      <= '0;
      req_left_q <= '0;
      inflight_q <= '0;
      acks_q     <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_len_q   <= '0;
    end else begin
      req_left_q <= req_left_d;
      inflight_q <= inflight_d;
      acks_q     <= acks_d;
      if (rd_acc) rd_valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            len_q      <= num_lines;
            src_q      <= src_buf;
            dst_q      <= dst_buf;
            mode_q     <= mode;
            req_left_q <= num_lines;
            inflight_q <= '0;
            acks_q     <= '0;
            if (num_lines == '0) begin
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              finish_q <= 1'b1;
            end else begin
              state_q    <= S_RUN;
              busy_q     <= 1'b1;
              finish_q   <= 1'b0;
              rd_valid_q <= 1'b1;
              rd_len_q   <= pick_len({1'b0, num_lines}, cr_t'(FIFO_DEPTH));
            end
          end
        end
        S_RUN: begin
          if (rd_acc && (req_left_d == '0)) begin
            state_q <= S_DRAIN;
          end else if (!rd_valid_q && (req_left_q != '0) && (credit != '0)) begin
            rd_valid_q <= 1'b1;
            rd_len_q   <= pick_len({1'b0, req_left_q}, credit);
          end
        end
        S_DRAIN: begin
          if (drained) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            finish_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line storage; the transform is applied as responses are enqueued
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= mode_q ? ~rd_rsp_data : rd_rsp_data;
  end

  // FIFO pointers and the write output register, refilled whenever empty or accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      count_q    <= count_d;
      wr_valid_q <= wr_valid_d;
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        wr_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  assign busy         = busy_q;
  assign finish       = finish_q;
  assign rd_req_valid = rd_valid_q;
  assign rd_req_buf   = src_q;
  assign rd_req_len   = rd_len_q;
  assign wr_req_valid = wr_valid_q;
  assign wr_req_buf   = dst_q;
  assign wr_req_data  = wr_data_q;

endmodule
